rps_match_controller: RTL and testbench

//  Sequences a rock-paper-scissors match between two players on one clock.

---
 rtl/rps_pkg.sv | 35 +++
 rtl/rps_move_latch.sv | 64 ++++++
 rtl/rps_match_controller.sv | 161 ++++++++++++++++
 tb/tb_rps_match_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared types, result codes and the round-judging function for the
// rock-paper-scissors match controller.
package rps_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    ROCK     = 2'd1,
    PAPER    = 2'd2,
    SCISSORS = 2'd3
  } move_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_JUDGE   = 2'd1,
    ST_REVEAL  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;

  // Equal moves and any pairing involving NONE fall through to a tie.
  function automatic logic [1:0] judge(input move_t a, input move_t b);
    logic [1:0] r;
    r = RES_TIE;
    case ({a, b})
      {ROCK, SCISSORS}, {PAPER, ROCK}, {SCISSORS, PAPER}: r = RES_P1;
      {SCISSORS, ROCK}, {ROCK, PAPER}, {PAPER, SCISSORS}: r = RES_P2;
      default: r = RES_TIE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rps_move_latch.sv
// Per-player move capture: one-hot check, latched move, locked flag and
// single-cycle invalid pulse. clear has priority over any same-cycle lock.
module rps_move_latch
  import rps_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  enable,
  input  logic  rock,
  input  logic  paper,
  input  logic  scissors,
  input  logic  lock,
  output move_t move,
  output logic  locked,
  output logic  invalid,
  output logic  accept
);

  move_t move_in_s;
  move_t move_r;
  logic  onehot_s;
  logic  take_s;
  logic  locked_r;
  logic  invalid_r;

  // Decode the switch levels; anything other than exactly one high is NONE.
  always_comb begin
    move_in_s = NONE;
    case ({rock, paper, scissors})
      3'b100:  move_in_s = ROCK;
      3'b010:  move_in_s = PAPER;
      3'b001:  move_in_s = SCISSORS;
      default: move_in_s = NONE;
    endcase
    onehot_s = (move_in_s != NONE);
    take_s   = enable & lock & ~locked_r & ~clear;
    accept   = take_s & onehot_s;
  end

  // Capture state: move, locked flag and the invalid strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_r    <= NONE;
      locked_r  <= 1'b0;
      invalid_r <= 1'b0;
    end else if (clear) begin
      move_r    <= NONE;
      locked_r  <= 1'b0;
      invalid_r <= 1'b0;
    end else begin
      invalid_r <= take_s & ~onehot_s;
      if (accept) begin
        move_r   <= move_in_s;
        locked_r <= 1'b1;
      end
    end
  end

  assign move    = move_r;
  assign locked  = locked_r;
  assign invalid = invalid_r;

endmodule

// File: rtl/rps_match_controller.sv
// Match sequencer: collects both players' moves, judges the round, holds
// the result for a reveal window and stops when a player reaches WIN_SCORE.
module rps_match_controller
  import rps_pkg::*;
#(
  parameter logic [3:0] WIN_SCORE     = 4'd10,
  parameter int         REVEAL_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       rock1,
  input  logic       paper1,
  input  logic       scissors1,
  input  logic       rock2,
  input  logic       paper2,
  input  logic       scissors2,
  input  logic       lock1,
  input  logic       lock2,
  output logic [1:0] result,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [4:0] round_cnt,
  output logic       p1_locked,
  output logic       p2_locked,
  output logic       invalid1,
  output logic       invalid2,
  output logic       reveal,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int          CW   = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REVEAL_CYCLES - 1);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          clear_s, enable_s, win_reached_s;
  logic [1:0]    judge_s;

  move_t move1_s, move2_s;
  logic  locked1_s, locked2_s, invalid1_s, invalid2_s, accept1_s, accept2_s;

  logic [1:0] result_r, winner_r;
  logic [3:0] score1_r, score2_r;
  logic [4:0] round_r;
  logic       reveal_r, match_over_r;

  rps_move_latch u_p1 (
    .clk(clk), .rst(rst), .clear(clear_s), .enable(enable_s),
    .rock(rock1), .paper(paper1), .scissors(scissors1), .lock(lock1),
    .move(move1_s), .locked(locked1_s), .invalid(invalid1_s), .accept(accept1_s)
  );

  rps_move_latch u_p2 (
    .clk(clk), .rst(rst), .clear(clear_s), .enable(enable_s),
    .rock(rock2), .paper(paper2), .scissors(scissors2), .lock(lock2),
    .move(move2_s), .locked(locked2_s), .invalid(invalid2_s), .accept(accept2_s)
  );

  // FSM state and reveal counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_COLLECT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; locks are cleared on new_game or on returning to COLLECT.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    clear_s       = 1'b0;
    enable_s      = (state_r == ST_COLLECT);
    win_reached_s = (score1_r == WIN_SCORE) || (score2_r == WIN_SCORE);
    judge_s       = judge(move1_s, move2_s);
    if (new_game) begin
      state_s = ST_COLLECT;
      cnt_s   = '0;
      clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if ((locked1_s | accept1_s) & (locked2_s | accept2_s)) begin
            state_s = ST_JUDGE;
          end else begin
            state_s = ST_COLLECT;
          end
        end
        ST_JUDGE: begin
          state_s = ST_REVEAL;
          cnt_s   = '0;
        end
        ST_REVEAL: begin
          if (cnt_r == LAST) begin
            cnt_s = '0;
            if (win_reached_s) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_COLLECT;
              clear_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        ST_DONE:  state_s = ST_DONE;
        default:  state_s = ST_COLLECT;
      endcase
    end
  end

  // Round result, scores, round count and the registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r     <= RES_TIE;
      score1_r     <= 4'd0;
      score2_r     <= 4'd0;
      round_r      <= 5'd0;
      reveal_r     <= 1'b0;
      match_over_r <= 1'b0;
      winner_r     <= 2'b00;
    end else if (new_game) begin
      result_r     <= RES_TIE;
      score1_r     <= 4'd0;
      score2_r     <= 4'd0;
      round_r      <= 5'd0;
      reveal_r     <= 1'b0;
      match_over_r <= 1'b0;
      winner_r     <= 2'b00;
    end else begin
      reveal_r     <= (state_s == ST_REVEAL);
      match_over_r <= (state_s == ST_DONE);
      if (state_r == ST_JUDGE) begin
        result_r <= judge_s;
        if (round_r != 5'd31) round_r <= round_r + 5'd1;
        if (judge_s == RES_P1 && score1_r < WIN_SCORE) score1_r <= score1_r + 4'd1;
        if (judge_s == RES_P2 && score2_r < WIN_SCORE) score2_r <= score2_r + 4'd1;
      end
      if (state_r == ST_REVEAL && state_s == ST_DONE) begin
        winner_r <= (score1_r == WIN_SCORE) ? RES_P1 : RES_P2;
      end
    end
  end

  assign result     = result_r;
  assign score1     = score1_r;
  assign score2     = score2_r;
  assign round_cnt  = round_r;
  assign p1_locked  = locked1_s;
  assign p2_locked  = locked2_s;
  assign invalid1   = invalid1_s;
  assign invalid2   = invalid2_s;
  assign reveal     = reveal_r;
  assign match_over = match_over_r;
  assign winner     = winner_r;

endmodule

// File: tb/tb_rps_match_controller.sv
// Scoreboard bench: stimulus queues expected round outcomes and invalid
// pulses; a negedge monitor pops and compares them as the DUT presents them.
module tb_rps_match_controller;

  localparam int         RC = 4;
  localparam logic [3:0] WS = 4'd3;

  logic       clk = 1'b0;
  logic       rst, new_game;
  logic       rock1, paper1, scissors1, rock2, paper2, scissors2, lock1, lock2;
  logic [1:0] result, winner;
  logic [3:0] score1, score2;
  logic [4:0] round_cnt;
  logic       p1_locked, p2_locked, invalid1, invalid2, reveal, match_over;

  rps_match_controller #(.WIN_SCORE(WS), .REVEAL_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .rock1(rock1), .paper1(paper1), .scissors1(scissors1),
    .rock2(rock2), .paper2(paper2), .scissors2(scissors2),
    .lock1(lock1), .lock2(lock2),
    .result(result), .score1(score1), .score2(score2), .round_cnt(round_cnt),
    .p1_locked(p1_locked), .p2_locked(p2_locked),
    .invalid1(invalid1), .invalid2(invalid2),
    .reveal(reveal), .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] res;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [4:0] rc;
    logic       done;
    logic [1:0] win;
  } exp_t;

  exp_t exp_q[$];
  bit   inv1_q[$];
  bit   inv2_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_moves(input logic [2:0] m1, input logic [2:0] m2);
    {rock1, paper1, scissors1} = m1;
    {rock2, paper2, scissors2} = m2;
  endtask

  task automatic pulse(input logic l1, input logic l2, input logic ng);
    lock1 = l1; lock2 = l2; new_game = ng;
    tick();
    lock1 = 1'b0; lock2 = 1'b0; new_game = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] res, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [4:0] rc, input logic done, input logic [1:0] win);
    exp_t e;
    e.res = res; e.s1 = s1; e.s2 = s2; e.rc = rc; e.done = done; e.win = win;
    exp_q.push_back(e);
  endtask

  task automatic wait_round();
    repeat (7) tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, result, score1, score2, round_cnt, p1_locked, p2_locked,
            invalid1, invalid2, reveal, match_over, winner};
  endfunction

  // Monitor: round results on reveal rise, reveal length/exit on fall, invalid pulses.
  initial begin
    logic rv_prev;
    int   rv_len;
    exp_t cur;
    rv_prev = 1'b0;
    rv_len  = 0;
    cur     = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rv_prev = 1'b0;
        rv_len  = 0;
      end else begin
        if (invalid1) begin
          check("invalid1_expected", 32'(inv1_q.size() > 0), 32'd1);
          if (inv1_q.size() > 0) void'(inv1_q.pop_front());
        end
        if (invalid2) begin
          check("invalid2_expected", 32'(inv2_q.size() > 0), 32'd1);
          if (inv2_q.size() > 0) void'(inv2_q.pop_front());
        end
        if (reveal && !rv_prev) begin
          rv_len = 1;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_reveal: got reveal=1, expected no round pending (t=%0t)", $time);
          end else begin
            cur = exp_q.pop_front();
            check("result", 32'(result), 32'(cur.res));
            check("score1", 32'(score1), 32'(cur.s1));
            check("score2", 32'(score2), 32'(cur.s2));
            check("round_cnt", 32'(round_cnt), 32'(cur.rc));
          end
        end else if (reveal) begin
          rv_len++;
        end
        if (!reveal && rv_prev) begin
          check("reveal_len", 32'(rv_len), 32'(RC));
          check("match_over", 32'(match_over), 32'(cur.done));
          check("winner", 32'(winner), 32'(cur.win));
          if (!cur.done) check("locks_cleared", 32'({p1_locked, p2_locked}), 32'd0);
        end
        rv_prev = reveal;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; new_game = 1'b0; lock1 = 1'b0; lock2 = 1'b0;
    set_moves(3'b000, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    tick();

    // Basic round, P1 rock vs P2 scissors; P1 changes switches after locking.
    set_moves(3'b100, 3'b000);
    pulse(1'b1, 1'b0, 1'b0);
    check("p1_locked_after_lock", 32'(p1_locked), 32'd1);
    check("p2_locked_idle", 32'(p2_locked), 32'd0);
    set_moves(3'b010, 3'b000);
    tick(); tick();
    set_moves(3'b010, 3'b001);
    push_exp(2'b01, 4'd1, 4'd0, 5'd1, 1'b0, 2'b00);
    pulse(1'b0, 1'b1, 1'b0);
    check("result_t_plus_1", 32'(result), 32'd0);
    tick();
    check("result_t_plus_2", 32'(result), 32'd1);
    check("reveal_t_plus_2", 32'(reveal), 32'd1);
    repeat (5) tick();

    // Invalid locks and re-lock while locked.
    set_moves(3'b110, 3'b000);
    inv1_q.push_back(1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check("p1_unlocked_two_moves", 32'(p1_locked), 32'd0);
    set_moves(3'b000, 3'b000);
    inv1_q.push_back(1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check("p1_unlocked_no_move", 32'(p1_locked), 32'd0);
    set_moves(3'b010, 3'b000);
    pulse(1'b1, 1'b0, 1'b0);
    check("p1_locked_paper", 32'(p1_locked), 32'd1);
    set_moves(3'b110, 3'b000);
    pulse(1'b1, 1'b0, 1'b0);
    check("p1_still_locked", 32'(p1_locked), 32'd1);
    set_moves(3'b000, 3'b100);
    push_exp(2'b01, 4'd2, 4'd0, 5'd2, 1'b0, 2'b00);
    pulse(1'b0, 1'b1, 1'b0);
    wait_round();

    pulse(1'b0, 1'b0, 1'b1);
    check("new_game_clear", all_outs(), 32'd0);

    // Same-cycle locks, paper vs paper.
    set_moves(3'b010, 3'b010);
    push_exp(2'b00, 4'd0, 4'd0, 5'd1, 1'b0, 2'b00);
    pulse(1'b1, 1'b1, 1'b0);
    wait_round();

    // P2 takes three rounds with paper over rock.
    for (int i = 1; i <= 3; i++) begin
      set_moves(3'b100, 3'b010);
      push_exp(2'b10, 4'd0, 4'(i), 5'(i + 1), (i == 3), (i == 3) ? 2'b10 : 2'b00);
      pulse(1'b1, 1'b1, 1'b0);
      wait_round();
    end
    set_moves(3'b001, 3'b100);
    pulse(1'b1, 1'b1, 1'b0);
    set_moves(3'b110, 3'b000);
    pulse(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("done_score2", 32'(score2), 32'd3);
    check("done_round_cnt", 32'(round_cnt), 32'd4);
    check("done_match_over", 32'(match_over), 32'd1);
    check("done_winner", 32'(winner), 32'd2);
    pulse(1'b0, 1'b0, 1'b1);
    check("restart_clear", all_outs(), 32'd0);

    // new_game beats a coincident valid lock.
    set_moves(3'b100, 3'b000);
    pulse(1'b1, 1'b0, 1'b1);
    check("ng_lock_dropped", 32'(p1_locked), 32'd0);
    check("ng_scores", 32'({score1, score2}), 32'd0);
    tick();

    // Reset in the middle of REVEAL.
    set_moves(3'b100, 3'b001);
    push_exp(2'b01, 4'd1, 4'd0, 5'd1, 1'b0, 2'b00);
    pulse(1'b1, 1'b1, 1'b0);
    tick(); tick();
    check("reveal_before_reset", 32'(reveal), 32'd1);
    rst = 1'b0;
    #1;
    check("reset_mid_reveal", all_outs(), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("post_reset_idle", 32'({p1_locked, p2_locked, reveal, match_over}), 32'd0);
    set_moves(3'b001, 3'b100);
    push_exp(2'b10, 4'd0, 4'd1, 5'd1, 1'b0, 2'b00);
    pulse(1'b1, 1'b1, 1'b0);
    wait_round();

    repeat (3) tick();
    check("rounds_pending", 32'(exp_q.size()), 32'd0);
    check("invalid1_pending", 32'(inv1_q.size()), 32'd0);
    check("invalid2_pending", 32'(inv2_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
